store_unit: RTL and testbench
=============================

# store_unit

Memory-stage store path, the write-side counterpart of the load formatting done at writeback. Accepts a store (sw/sh/sb) from the execute stage, places the register data in the correct big-endian byte lane(s) and drives the single-port, word-wide data memory. Word stores are written directly. Halfword and byte stores are done as a read-modify-write, because the data memory has no byte enables. Misaligned stores are rejected with an error pulse and leave memory untouched.

## Interface
- RD_LAT, 1: data memory read latency in cycles, from mem_re to valid mem_rdata; legal range 1..4.
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request present.
- st_ready  out  1  unit idle and able to accept; high exactly when the FSM is in IDLE.
- st_addr  in  32  byte address of the store.
- st_data  in  32  register (rt) value; the low bits hold the sub-word.
- mem_write_size  in  2  0 = word, 1 = halfword, 2 and 3 = byte (same encoding as mem_read_size).
- st_done  out  1  one-cycle pulse in the cycle the memory write is issued.
- st_err  out  1  one-cycle pulse for a misaligned store; no memory access.
- mem_addr  out  32  word-aligned byte address; bits [1:0] are always 0.
- mem_re  out  1  memory read strobe, one cycle.
- mem_we  out  1  memory write strobe, one cycle.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  read data, valid RD_LAT cycles after mem_re.

## Operation
- Handshake: a request is accepted in a cycle with st_valid && st_ready. st_addr, st_data and mem_write_size are captured in that cycle and are don't-care afterwards.
- Lane mapping is big-endian:
  - Byte offset 0 is bits [31:24], offset 1 is [23:16], offset 2 is [15:8], offset 3 is [7:0].
  - A halfword at offset 0 is [31:16]; at offset 2 it is [15:0].
- Alignment rules:
  - A word requires st_addr[1:0]==0.
  - A halfword requires st_addr[0]==0.
  - A byte store is always aligned.
  - A violation sends the FSM to ERR.
- States and transitions:
  - IDLE -> WR for an aligned word store.
  - IDLE -> RD for an aligned halfword or byte store.
  - IDLE -> ERR for a misaligned store.
  - RD: mem_re=1 for one cycle, then -> WAIT.
  - WAIT: a counter runs from RD_LAT-1 down to 0. When mem_rdata is valid, the merged word is registered: the captured lane(s) are replaced with st_data[7:0] or st_data[15:0] and all other bits come from mem_rdata. Then -> WR.
  - WR: mem_we=1 and st_done=1, with mem_wdata equal to either the word data or the merged word. Then -> IDLE.
  - ERR: st_err=1, mem_re=0, mem_we=0. Then -> IDLE.
- mem_addr equals {captured_addr[31:2],2'b00} from acceptance until return to IDLE. In IDLE it holds its last value (0 after reset).
- Unused upper bits of st_data are ignored for sub-word stores.
- Only one store is outstanding at a time; no queuing.

## Timing
- Reset (asynchronous, while reset_n=0):
  - State is IDLE.
  - st_done, st_err, mem_re, mem_we are 0; mem_addr and mem_wdata are 0.
  - st_ready is 1.
- Release of reset is synchronous to clk.
- Reset asserted mid-operation aborts the store immediately. mem_we is never asserted for the aborted store and st_done is not pulsed.
- With acceptance in cycle 0:
  - Word: mem_we and st_done in cycle 1; st_ready high again in cycle 2.
  - Halfword or byte: mem_re in cycle 1; mem_rdata sampled at the end of cycle 1+RD_LAT; mem_we and st_done in cycle 2+RD_LAT; st_ready in cycle 3+RD_LAT.
  - Misaligned: st_err in cycle 1; st_ready in cycle 2.
- All outputs are registered, with no combinational path from input to output. The exception is st_ready, which is decoded from the state register only.
- st_ready is low in every non-IDLE cycle. A request held on st_valid is accepted in the first IDLE cycle.
- Back-to-back acceptance: a new store may be accepted in the same cycle st_ready returns high. There are no idle bubbles beyond those listed above.
- mem_re and mem_we are never high in the same cycle.

## Test plan
- Reset then word store: st_addr=0x100, st_data=0xDEADBEEF, size 0 -> cycle 1 has mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, st_done=1; st_ready=1 in cycle 2.
- Byte store, RD_LAT=1: st_addr=0x203, st_data=0x000000AB, size 2, memory word 0x11223344 -> mem_re in cycle 1 with mem_addr=0x200; mem_we in cycle 3 with mem_wdata=0x112233AB; repeat at offset 0 -> 0xAB223344.
- Halfword store, RD_LAT=3: st_addr=0x302, st_data=0xFFFF5566, size 1, memory 0xAAAABBBB -> mem_we in cycle 5 with mem_wdata=0xAAAA5566; st_ready stays low for cycles 1-5.
- Misaligned: halfword at 0x401 and word at 0x402 -> st_err pulses in cycle 1 each time; mem_re and mem_we stay 0; st_ready in cycle 2.
- Back-to-back: hold st_valid with a word store followed by a byte store -> the second is accepted in cycle 2; exactly one st_done per store.
- Abort: assert reset_n=0 during WAIT of a byte store -> mem_we never asserted; all outputs 0; st_ready=1 immediately.

Source files
------------

// File: rtl/store_unit.sv
// store_unit: memory-stage store path. Places sw/sh/sb data into big-endian
// byte lanes and drives a word-wide data memory. Sub-word stores use a
// read-modify-write because the memory has no byte enables.
module store_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    input  logic [1:0]  mem_write_size,
    output logic        st_done,
    output logic        st_err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  cnt;
    logic [1:0]  cap_off;
    logic        cap_byte;
    logic [15:0] cap_data;
    logic        accept;
    logic        is_word;
    logic        is_half;
    logic        aligned;

    // Replace the addressed lane(s) of the read word with the store data.
    // Big-endian: byte offset 0 is the most significant byte.
    function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic        is_byte,
                                               input logic [15:0] data);
        logic [31:0] res;
        res = word;
        if (is_byte) begin
            case (off)
                2'd0:    res[31:24] = data[7:0];
                2'd1:    res[23:16] = data[7:0];
                2'd2:    res[15:8]  = data[7:0];
                default: res[7:0]   = data[7:0];
            endcase
        end else if (off[1]) begin
            res[15:0] = data;
        end else begin
            res[31:16] = data;
        end
        return res;
    endfunction

    // Request decode: acceptance, size class and alignment of the incoming store.
    always_comb begin
        accept  = st_valid && (state == IDLE);
        is_word = (mem_write_size == 2'd0);
        is_half = (mem_write_size == 2'd1);
        aligned = 1'b1;
        if (is_word) begin
            aligned = (st_addr[1:0] == 2'b00);
        end else if (is_half) begin
            aligned = ~st_addr[0];
        end
    end

    // Next-state logic of the store sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!aligned) begin
                        state_next = ERR;
                    end else if (is_word) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD:      state_next = WAIT;
            WAIT:    if (cnt == 2'd0) state_next = WR;
            WR:      state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Ready is a pure decode of the state register.
    assign st_ready = (state == IDLE);

    // State, strobes, address and write data; strobes are registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            st_done   <= 1'b0;
            st_err    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else begin
            state   <= state_next;
            mem_re  <= (state_next == RD);
            mem_we  <= (state_next == WR);
            st_done <= (state_next == WR);
            st_err  <= (state_next == ERR);
            if (accept) begin
                mem_addr <= {st_addr[31:2], 2'b00};
            end
            if (state == RD) begin
                cnt <= 2'(RD_LAT - 1);
            end else if (state == WAIT && cnt != 2'd0) begin
                cnt <= cnt - 2'd1;
            end
            if (accept && aligned && is_word) begin
                mem_wdata <= st_data;
            end else if (state == WAIT && cnt == 2'd0) begin
                mem_wdata <= merge_lane(mem_rdata, cap_off, cap_byte, cap_data);
            end
        end
    end

    // Sub-word store operands captured at acceptance; pure data, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            cap_off  <= st_addr[1:0];
            cap_byte <= mem_write_size[1];
            cap_data <= st_data[15:0];
        end
    end

endmodule

// File: tb/tb_store_unit.sv
// tb_store_unit: directed bench for store_unit with two instances
// (RD_LAT=1 and RD_LAT=3) and a write scoreboard.
module tb_store_unit;

    logic        clk;
    logic        reset_n;
    logic        sel;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;

    logic        ready_a, done_a, err_a, re_a, we_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        ready_b, done_b, err_b, re_b, we_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    logic [31:0] word_a, word_b;
    logic [3:0]  pipe_a, pipe_b;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;
    wr_t sb[$];

    store_unit #(.RD_LAT(1)) u_a (
        .clk(clk), .reset_n(reset_n), .st_valid(st_valid && !sel), .st_ready(ready_a),
        .st_addr(st_addr), .st_data(st_data), .mem_write_size(st_size),
        .st_done(done_a), .st_err(err_a), .mem_addr(addr_a), .mem_re(re_a),
        .mem_we(we_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a)
    );

    store_unit #(.RD_LAT(3)) u_b (
        .clk(clk), .reset_n(reset_n), .st_valid(st_valid && sel), .st_ready(ready_b),
        .st_addr(st_addr), .st_data(st_data), .mem_write_size(st_size),
        .st_done(done_b), .st_err(err_b), .mem_addr(addr_b), .mem_re(re_b),
        .mem_we(we_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b)
    );

    wire        o_ready = sel ? ready_b : ready_a;
    wire        o_done  = sel ? done_b  : done_a;
    wire        o_err   = sel ? err_b   : err_a;
    wire        o_re    = sel ? re_b    : re_a;
    wire        o_we    = sel ? we_b    : we_a;
    wire [31:0] o_addr  = sel ? addr_b  : addr_a;
    wire [31:0] o_wdata = sel ? wdata_b : wdata_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory models: read data is valid only exactly RD_LAT cycles after mem_re.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_a <= 4'd0;
            pipe_b <= 4'd0;
        end else begin
            pipe_a <= {pipe_a[2:0], re_a};
            pipe_b <= {pipe_b[2:0], re_b};
        end
    end
    assign rdata_a = pipe_a[0] ? word_a : 32'hBAD0BAD0;
    assign rdata_b = pipe_b[2] ? word_b : 32'hBAD0BAD0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every memory write is matched against the next queued expectation.
    always @(negedge clk) begin
        if (done_a || done_b) done_cnt++;
        if (we_a || we_b) begin
            compared++;
            assert (sb.size() != 0) else begin
                mismatched++;
                $error("FAIL unexpected_write observed=addr %h data %h expected=none",
                       we_a ? addr_a : addr_b, we_a ? wdata_a : wdata_b);
            end
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                chk("sb_addr", we_a ? addr_a : addr_b, e.addr);
                chk("sb_wdata", we_a ? wdata_a : wdata_b, e.data);
                chk("sb_re_we_excl", {31'd0, (we_a & re_a) | (we_b & re_b)}, 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start(input logic s, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] z);
        sel      = s;
        st_addr  = a;
        st_data  = d;
        st_size  = z;
        st_valid = 1'b1;
    endtask

    initial begin
        int d0;
        reset_n  = 1'b0;
        sel      = 1'b0;
        st_valid = 1'b0;
        st_addr  = 32'd0;
        st_data  = 32'd0;
        st_size  = 2'd0;
        word_a   = 32'h11223344;
        word_b   = 32'hAAAABBBB;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        chk("rst_strobes", {28'd0, o_done, o_err, o_re, o_we}, 32'd0);
        chk("rst_addr", o_addr, 32'd0);
        chk("rst_wdata", o_wdata, 32'd0);
        chk("rst_ready_b", {31'd0, ready_b}, 32'd1);
        reset_n = 1'b1;
        tick();

        // Word store
        start(1'b0, 32'h100, 32'hDEADBEEF, 2'd0);
        sb.push_back('{addr: 32'h100, data: 32'hDEADBEEF});
        chk("w_ready_c0", {31'd0, o_ready}, 32'd1);
        tick(); st_valid = 1'b0;
        chk("w_we_c1", {31'd0, o_we}, 32'd1);
        chk("w_done_c1", {31'd0, o_done}, 32'd1);
        chk("w_addr_c1", o_addr, 32'h100);
        chk("w_wdata_c1", o_wdata, 32'hDEADBEEF);
        chk("w_ready_c1", {31'd0, o_ready}, 32'd0);
        tick();
        chk("w_ready_c2", {31'd0, o_ready}, 32'd1);
        chk("w_done_c2", {31'd0, o_done}, 32'd0);

        // Byte store at offset 3, RD_LAT=1
        start(1'b0, 32'h203, 32'h000000AB, 2'd2);
        sb.push_back('{addr: 32'h200, data: 32'h112233AB});
        tick(); st_valid = 1'b0;
        chk("b3_re_c1", {31'd0, o_re}, 32'd1);
        chk("b3_addr_c1", o_addr, 32'h200);
        chk("b3_we_c1", {31'd0, o_we}, 32'd0);
        tick();
        chk("b3_strobes_c2", {30'd0, o_re, o_we}, 32'd0);
        chk("b3_ready_c2", {31'd0, o_ready}, 32'd0);
        tick();
        chk("b3_we_c3", {31'd0, o_we}, 32'd1);
        chk("b3_done_c3", {31'd0, o_done}, 32'd1);
        chk("b3_wdata_c3", o_wdata, 32'h112233AB);
        tick();
        chk("b3_ready_c4", {31'd0, o_ready}, 32'd1);

        // Byte store at offset 0, upper data bits ignored
        start(1'b0, 32'h200, 32'h123456AB, 2'd3);
        sb.push_back('{addr: 32'h200, data: 32'hAB223344});
        tick(); st_valid = 1'b0;
        tick(); tick();
        chk("b0_we_c3", {31'd0, o_we}, 32'd1);
        chk("b0_wdata_c3", o_wdata, 32'hAB223344);
        tick();

        // Halfword store at offset 2, RD_LAT=3
        start(1'b1, 32'h302, 32'hFFFF5566, 2'd1);
        sb.push_back('{addr: 32'h300, data: 32'hAAAA5566});
        tick(); st_valid = 1'b0;
        chk("h_re_c1", {31'd0, o_re}, 32'd1);
        chk("h_addr_c1", o_addr, 32'h300);
        for (int c = 1; c <= 5; c++) begin
            chk($sformatf("h_ready_c%0d", c), {31'd0, o_ready}, 32'd0);
            if (c == 4) chk("h_we_c4", {31'd0, o_we}, 32'd0);
            if (c < 5) tick();
        end
        chk("h_we_c5", {31'd0, o_we}, 32'd1);
        chk("h_wdata_c5", o_wdata, 32'hAAAA5566);
        tick();
        chk("h_ready_c6", {31'd0, o_ready}, 32'd1);

        // Halfword at offset 0, RD_LAT=3
        start(1'b1, 32'h300, 32'h00001234, 2'd1);
        sb.push_back('{addr: 32'h300, data: 32'h1234BBBB});
        tick(); st_valid = 1'b0;
        repeat (4) tick();
        chk("h0_wdata_c5", o_wdata, 32'h1234BBBB);
        tick();

        // Misaligned halfword and word
        start(1'b0, 32'h401, 32'h0000FFFF, 2'd1);
        tick(); st_valid = 1'b0;
        chk("mh_err_c1", {31'd0, o_err}, 32'd1);
        chk("mh_strobes_c1", {30'd0, o_re, o_we}, 32'd0);
        tick();
        chk("mh_ready_c2", {31'd0, o_ready}, 32'd1);
        chk("mh_err_c2", {31'd0, o_err}, 32'd0);
        start(1'b0, 32'h402, 32'hCAFEF00D, 2'd0);
        tick(); st_valid = 1'b0;
        chk("mw_err_c1", {31'd0, o_err}, 32'd1);
        chk("mw_strobes_c1", {30'd0, o_re, o_we}, 32'd0);
        tick();
        chk("mw_ready_c2", {31'd0, o_ready}, 32'd1);
        chk("mw_strobes_c2", {29'd0, o_err, o_re, o_we}, 32'd0);

        // Back-to-back with st_valid held: word then byte
        d0 = done_cnt;
        start(1'b0, 32'h500, 32'h01020304, 2'd0);
        sb.push_back('{addr: 32'h500, data: 32'h01020304});
        sb.push_back('{addr: 32'h500, data: 32'h11CD3344});
        tick();
        start(1'b0, 32'h501, 32'h000000CD, 2'd3);
        chk("bb_we_c1", {31'd0, o_we}, 32'd1);
        tick();
        chk("bb_ready_c2", {31'd0, o_ready}, 32'd1);
        tick(); st_valid = 1'b0;
        chk("bb_re_c3", {31'd0, o_re}, 32'd1);
        tick(); tick();
        chk("bb_we_c5", {31'd0, o_we}, 32'd1);
        tick(); tick();
        chk("bb_done_count", done_cnt - d0, 32'd2);

        // Abort during WAIT of a byte store
        d0 = done_cnt;
        start(1'b0, 32'h600, 32'h00000077, 2'd2);
        tick(); st_valid = 1'b0;
        chk("ab_re_c1", {31'd0, o_re}, 32'd1);
        tick();
        reset_n = 1'b0;
        #1;
        chk("ab_ready", {31'd0, o_ready}, 32'd1);
        chk("ab_strobes", {28'd0, o_done, o_err, o_re, o_we}, 32'd0);
        chk("ab_addr", o_addr, 32'd0);
        chk("ab_wdata", o_wdata, 32'd0);
        @(negedge clk);
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        chk("ab_no_done", done_cnt - d0, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
